// File: rtl/axi_err_monitor.sv
// rtl/axi_err_monitor.sv - passive AXI error snoop: outstanding-address FIFOs, error counters, first-error capture
// Optional AXI_ERR_MON_ID_EN adds ID ports, ID storage beside addresses and an ERR_ID capture.

module axi_err_mon_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         ovf_evt
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         empty, full, do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    do_push = push && (!full || do_pop);
    ovf_evt = (push && full && !do_pop) || (pop && empty);
    head    = empty ? '0 : mem_q[rd_q[AW-1:0]];
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d                = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

module axi_err_monitor #(
  parameter int WIDTH_SID = 8,
  parameter int WIDTH_AD  = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [WIDTH_AD-1:0]  AWADDR,
  input  logic                 AWVALID,
  input  logic                 AWREADY,
  input  logic [1:0]           BRESP,
  input  logic                 BVALID,
  input  logic                 BREADY,
  input  logic [WIDTH_AD-1:0]  ARADDR,
  input  logic                 ARVALID,
  input  logic                 ARREADY,
  input  logic [1:0]           RRESP,
  input  logic                 RLAST,
  input  logic                 RVALID,
  input  logic                 RREADY,
  input  logic                 CLR,
`ifdef AXI_ERR_MON_ID_EN
  input  logic [WIDTH_SID-1:0] AWID,
  input  logic [WIDTH_SID-1:0] BID,
  input  logic [WIDTH_SID-1:0] ARID,
  input  logic [WIDTH_SID-1:0] RID,
  output logic [WIDTH_SID-1:0] ERR_ID,
`endif
  output logic [15:0]          WERR_CNT,
  output logic [15:0]          RERR_CNT,
  output logic                 ERR_VALID,
  output logic [WIDTH_AD-1:0]  ERR_ADDR,
  output logic [1:0]           ERR_RESP,
  output logic                 ERR_WRITE,
  output logic                 OVF,
  output logic                 ERR_IRQ
);
`ifdef AXI_ERR_MON_ID_EN
  localparam int EW = WIDTH_AD + WIDTH_SID;
`else
  localparam int EW = WIDTH_AD;
`endif

  logic          w_push, w_pop, r_push, r_beat, r_last;
  logic          w_ovf_evt, r_ovf_evt, id_bad;
  logic [EW-1:0] w_push_data, r_push_data, w_head, r_head;
  logic          w_err, r_err;
  logic [1:0]    r_err_resp;

  logic          rsticky_q, rsticky_d;
  logic [1:0]    rsticky_resp_q, rsticky_resp_d;
  logic [15:0]   werr_cnt_q, werr_cnt_d, rerr_cnt_q, rerr_cnt_d;
  logic          err_valid_q, err_valid_d, err_write_q, err_write_d, ovf_q, ovf_d;
  logic [WIDTH_AD-1:0] err_addr_q, err_addr_d;
  logic [1:0]    err_resp_q, err_resp_d;
`ifdef AXI_ERR_MON_ID_EN
  logic [WIDTH_SID-1:0] err_id_q, err_id_d;
`endif

  assign w_push = AWVALID && AWREADY;
  assign w_pop  = BVALID && BREADY;
  assign r_push = ARVALID && ARREADY;
  assign r_beat = RVALID && RREADY;
  assign r_last = r_beat && RLAST;

`ifdef AXI_ERR_MON_ID_EN
  assign w_push_data = {AWID, AWADDR};
  assign r_push_data = {ARID, ARADDR};
  assign id_bad = (w_pop && (BID != w_head[EW-1:WIDTH_AD])) ||
                  (r_beat && (RID != r_head[EW-1:WIDTH_AD]));
`else
  assign w_push_data = AWADDR;
  assign r_push_data = ARADDR;
  assign id_bad      = 1'b0;
`endif

  axi_err_mon_fifo #(.W(EW), .DEPTH(DEPTH)) u_wfifo (
    .ACLK(ACLK), .ARESETn(ARESETn), .push(w_push), .push_data(w_push_data),
    .pop(w_pop), .head(w_head), .ovf_evt(w_ovf_evt)
  );

  axi_err_mon_fifo #(.W(EW), .DEPTH(DEPTH)) u_rfifo (
    .ACLK(ACLK), .ARESETn(ARESETn), .push(r_push), .push_data(r_push_data),
    .pop(r_last), .head(r_head), .ovf_evt(r_ovf_evt)
  );

  always_comb begin
    w_err          = w_pop && BRESP[1];
    r_err          = r_last && (rsticky_q || RRESP[1]);
    r_err_resp     = rsticky_q ? rsticky_resp_q : RRESP;
    rsticky_d      = rsticky_q;
    rsticky_resp_d = rsticky_resp_q;
    if (r_last) begin
      rsticky_d = 1'b0;
    end else if (r_beat && RRESP[1] && !rsticky_q) begin
      rsticky_d      = 1'b1;
      rsticky_resp_d = RRESP;
    end

    // CLR zeroes the base value, so an error completing alongside it still lands.
    werr_cnt_d  = CLR ? 16'h0 : werr_cnt_q;
    rerr_cnt_d  = CLR ? 16'h0 : rerr_cnt_q;
    err_valid_d = CLR ? 1'b0 : err_valid_q;
    err_addr_d  = CLR ? '0 : err_addr_q;
    err_resp_d  = CLR ? 2'b00 : err_resp_q;
    err_write_d = CLR ? 1'b0 : err_write_q;
    ovf_d       = (CLR ? 1'b0 : ovf_q) || w_ovf_evt || r_ovf_evt || id_bad;
`ifdef AXI_ERR_MON_ID_EN
    err_id_d    = CLR ? '0 : err_id_q;
`endif

    if (w_err && werr_cnt_d != 16'hFFFF) begin
      werr_cnt_d = werr_cnt_d + 16'h1;
    end
    if (r_err && rerr_cnt_d != 16'hFFFF) begin
      rerr_cnt_d = rerr_cnt_d + 16'h1;
    end

    if (!err_valid_d && w_err) begin
      err_valid_d = 1'b1;
      err_addr_d  = w_head[WIDTH_AD-1:0];
      err_resp_d  = BRESP;
      err_write_d = 1'b1;
`ifdef AXI_ERR_MON_ID_EN
      err_id_d    = w_head[EW-1:WIDTH_AD];
`endif
    end else if (!err_valid_d && r_err) begin
      err_valid_d = 1'b1;
      err_addr_d  = r_head[WIDTH_AD-1:0];
      err_resp_d  = r_err_resp;
      err_write_d = 1'b0;
`ifdef AXI_ERR_MON_ID_EN
      err_id_d    = r_head[EW-1:WIDTH_AD];
`endif
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rsticky_q      <= 1'b0;
      rsticky_resp_q <= 2'b00;
      werr_cnt_q     <= 16'h0;
      rerr_cnt_q     <= 16'h0;
      err_valid_q    <= 1'b0;
      err_addr_q     <= '0;
      err_resp_q     <= 2'b00;
      err_write_q    <= 1'b0;
      ovf_q          <= 1'b0;
`ifdef AXI_ERR_MON_ID_EN
      err_id_q       <= '0;
`endif
    end else begin
      rsticky_q      <= rsticky_d;
      rsticky_resp_q <= rsticky_resp_d;
      werr_cnt_q     <= werr_cnt_d;
      rerr_cnt_q     <= rerr_cnt_d;
      err_valid_q    <= err_valid_d;
      err_addr_q     <= err_addr_d;
      err_resp_q     <= err_resp_d;
      err_write_q    <= err_write_d;
      ovf_q          <= ovf_d;
`ifdef AXI_ERR_MON_ID_EN
      err_id_q       <= err_id_d;
`endif
    end
  end

  assign WERR_CNT  = werr_cnt_q;
  assign RERR_CNT  = rerr_cnt_q;
  assign ERR_VALID = err_valid_q;
  assign ERR_ADDR  = err_addr_q;
  assign ERR_RESP  = err_resp_q;
  assign ERR_WRITE = err_write_q;
  assign OVF       = ovf_q;
  assign ERR_IRQ   = err_valid_q | ovf_q;
`ifdef AXI_ERR_MON_ID_EN
  assign ERR_ID    = err_id_q;
`endif
endmodule

// File: tb/tb_axi_err_monitor.sv
// tb/tb_axi_err_monitor.sv - scoreboard bench for axi_err_monitor (DEPTH=4, 32-bit addresses)
module tb_axi_err_monitor;
  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [31:0] AWADDR = '0, ARADDR = '0;
  logic        AWVALID = 0, AWREADY = 0, BVALID = 0, BREADY = 0;
  logic        ARVALID = 0, ARREADY = 0, RVALID = 0, RREADY = 0, RLAST = 0, CLR = 0;
  logic [1:0]  BRESP = '0, RRESP = '0;
  logic [15:0] WERR_CNT, RERR_CNT;
  logic        ERR_VALID, ERR_WRITE, OVF, ERR_IRQ;
  logic [31:0] ERR_ADDR;
  logic [1:0]  ERR_RESP;
`ifdef AXI_ERR_MON_ID_EN
  logic [7:0]  AWID = '0, BID = '0, ARID = '0, RID = '0;
  logic [7:0]  ERR_ID;
`endif

  always #5 ACLK = ~ACLK;

  axi_err_monitor #(.WIDTH_SID(8), .WIDTH_AD(32), .DEPTH(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CLR(CLR),
`ifdef AXI_ERR_MON_ID_EN
    .AWID(AWID), .BID(BID), .ARID(ARID), .RID(RID), .ERR_ID(ERR_ID),
`endif
    .WERR_CNT(WERR_CNT), .RERR_CNT(RERR_CNT), .ERR_VALID(ERR_VALID),
    .ERR_ADDR(ERR_ADDR), .ERR_RESP(ERR_RESP), .ERR_WRITE(ERR_WRITE),
    .OVF(OVF), .ERR_IRQ(ERR_IRQ)
  );

  typedef struct {
    string       tag;
    logic [15:0] wcnt;
    logic [15:0] rcnt;
    logic        ev;
    logic [31:0] addr;
    logic [1:0]  resp;
    logic        wr;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] wcnt, input logic [15:0] rcnt,
                            input logic ev, input logic [31:0] addr, input logic [1:0] resp,
                            input logic wr, input logic ovf);
    exp_t e;
    e.tag = tag; e.wcnt = wcnt; e.rcnt = rcnt; e.ev = ev;
    e.addr = addr; e.resp = resp; e.wr = wr; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic expect_zero(input string tag);
    expect_out(tag, 16'h0, 16'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic compare_out();
    exp_t e;
    e = exp_q.pop_front();
    check_val({e.tag, "_werr"}, {16'h0, WERR_CNT}, {16'h0, e.wcnt});
    check_val({e.tag, "_rerr"}, {16'h0, RERR_CNT}, {16'h0, e.rcnt});
    check_val({e.tag, "_valid"}, {31'h0, ERR_VALID}, {31'h0, e.ev});
    check_val({e.tag, "_addr"}, ERR_ADDR, e.addr);
    check_val({e.tag, "_resp"}, {30'h0, ERR_RESP}, {30'h0, e.resp});
    check_val({e.tag, "_write"}, {31'h0, ERR_WRITE}, {31'h0, e.wr});
    check_val({e.tag, "_ovf"}, {31'h0, OVF}, {31'h0, e.ovf});
    check_val({e.tag, "_irq"}, {31'h0, ERR_IRQ}, {31'h0, e.ev | e.ovf});
  endtask

  task automatic idle_inputs();
    AWVALID = 0; AWREADY = 0; BVALID = 0; BREADY = 0;
    ARVALID = 0; ARREADY = 0; RVALID = 0; RREADY = 0; RLAST = 0; CLR = 0;
  endtask

  // Registered outputs settle on the edge; compare 1 ns later.
  task automatic cyc();
    @(posedge ACLK);
    #1;
    idle_inputs();
    while (exp_q.size() > 0) compare_out();
  endtask

  task automatic aw(input logic [31:0] a);
    AWADDR = a; AWVALID = 1; AWREADY = 1; cyc();
  endtask
  task automatic ar(input logic [31:0] a);
    ARADDR = a; ARVALID = 1; ARREADY = 1; cyc();
  endtask
  task automatic b(input logic [1:0] resp);
    BRESP = resp; BVALID = 1; BREADY = 1; cyc();
  endtask
  task automatic r(input logic [1:0] resp, input logic last);
    RRESP = resp; RLAST = last; RVALID = 1; RREADY = 1; cyc();
  endtask
  task automatic awb(input logic [31:0] a, input logic [1:0] resp);
    AWADDR = a; AWVALID = 1; AWREADY = 1;
    BRESP = resp; BVALID = 1; BREADY = 1; cyc();
  endtask
  task automatic clr_all(input string tag);
    expect_zero(tag); CLR = 1; cyc();
  endtask

  initial begin
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1;
    expect_zero("reset"); cyc();

    // Write DECERR captured
    aw(32'h4000_0000);
    expect_out("t1", 16'd1, 16'd0, 1, 32'h4000_0000, 2'd3, 1, 0); b(2'd3);
    clr_all("clr1");

    // Read burst with two errored beats counts once, first bad RRESP kept
    ar(32'h8000_0010);
    r(2'd0, 0);
    expect_zero("t2_mid"); r(2'd2, 0);
    r(2'd3, 0);
    expect_out("t2", 16'd0, 16'd1, 1, 32'h8000_0010, 2'd2, 0, 0); r(2'd0, 1);
    ar(32'h8000_0020);
    r(2'd1, 0);
    expect_out("t2_lasterr", 16'd0, 16'd2, 1, 32'h8000_0010, 2'd2, 0, 0); r(2'd3, 1);
    ar(32'h8000_0030);
    expect_out("t2_okay", 16'd0, 16'd2, 1, 32'h8000_0010, 2'd2, 0, 0); r(2'd0, 1);
    clr_all("clr2");

    // Overflow: 5th AW dropped; stalled AW does not push
    AWADDR = 32'hDEAD_0000; AWVALID = 1; AWREADY = 0; cyc();
    aw(32'h100); aw(32'h104); aw(32'h108);
    expect_zero("t3_full"); aw(32'h10C);
    expect_out("t3_ovf", 16'd0, 16'd0, 0, 32'h0, 2'd0, 0, 1); aw(32'h110);
    b(2'd0); b(2'd0); b(2'd0);
    expect_out("t3_okb", 16'd0, 16'd0, 0, 32'h0, 2'd0, 0, 1); b(2'd0);
    expect_out("t3_empty", 16'd1, 16'd0, 1, 32'h0, 2'd2, 1, 1); b(2'd2);
    clr_all("clr3");

    // Full + push + pop: both happen, no overflow
    aw(32'h200); aw(32'h204); aw(32'h208); aw(32'h20C);
    expect_zero("t3_pp"); awb(32'h210, 2'd0);
    b(2'd0); b(2'd0); b(2'd0);
    expect_out("t3_pp_tail", 16'd1, 16'd0, 1, 32'h210, 2'd3, 1, 0); b(2'd3);
    clr_all("clr4");

    // Same-cycle write and read errors
    aw(32'h1000); ar(32'h2000);
    expect_out("t4", 16'd1, 16'd1, 1, 32'h1000, 2'd2, 1, 0);
    BRESP = 2'd2; BVALID = 1; BREADY = 1;
    RRESP = 2'd3; RLAST = 1; RVALID = 1; RREADY = 1; cyc();
    clr_all("clr5");

    // Pop on empty FIFO with same-cycle push
    expect_out("t_emptypush", 16'd1, 16'd0, 1, 32'h0, 2'd2, 1, 1); awb(32'h5555_0000, 2'd2);
    expect_out("t_drain", 16'd1, 16'd0, 1, 32'h0, 2'd2, 1, 1); b(2'd0);
    clr_all("clr6");

    // EXOKAY is not an error; error completing with CLR wins
    aw(32'hC0); aw(32'hC4); aw(32'hC8);
    expect_out("t_c0", 16'd1, 16'd0, 1, 32'hC0, 2'd2, 1, 0); b(2'd2);
    expect_out("t_exok", 16'd1, 16'd0, 1, 32'hC0, 2'd2, 1, 0); b(2'd1);
    expect_out("t_clrerr", 16'd1, 16'd0, 1, 32'hC8, 2'd3, 1, 0); CLR = 1; b(2'd3);
    clr_all("clr7");

    // Saturation
    aw(32'h2000_0000);
    for (int i = 0; i < 65533; i++) awb(32'h3000_0000 + i, 2'd2);
    expect_out("t5_fffe", 16'hFFFE, 16'd0, 1, 32'h2000_0000, 2'd2, 1, 0); awb(32'h3001_0000, 2'd2);
    expect_out("t5_sat1", 16'hFFFF, 16'd0, 1, 32'h2000_0000, 2'd2, 1, 0); awb(32'h3001_0001, 2'd3);
    awb(32'h3001_0002, 2'd2);
    expect_out("t5_sat3", 16'hFFFF, 16'd0, 1, 32'h2000_0000, 2'd2, 1, 0); awb(32'h3001_0003, 2'd2);
    expect_out("t5_last", 16'hFFFF, 16'd0, 1, 32'h2000_0000, 2'd2, 1, 0); b(2'd2);
    expect_out("t5_empty", 16'hFFFF, 16'd0, 1, 32'h2000_0000, 2'd2, 1, 1); b(2'd2);
    clr_all("clr8");

    // Reset mid-burst clears the read sticky flag and the FIFOs
    ar(32'h9000);
    r(2'd2, 0);
    ARESETn = 0;
    expect_zero("rst_hold"); cyc();
    ARESETn = 1;
    expect_out("rst_after", 16'd0, 16'd0, 0, 32'h0, 2'd0, 0, 1); r(2'd0, 1);
    clr_all("clr9");

`ifdef AXI_ERR_MON_ID_EN
    AWID = 8'd5; aw(32'hA000);
    BID = 8'd6;
    expect_out("t6_idbad", 16'd0, 16'd0, 0, 32'h0, 2'd0, 0, 1); b(2'd0);
    clr_all("clr10");
    AWID = 8'd5; aw(32'hAA00);
    BID = 8'd5;
    expect_out("t6_id", 16'd1, 16'd0, 1, 32'hAA00, 2'd3, 1, 0); b(2'd3);
    check_val("t6_err_id", {24'h0, ERR_ID}, 32'd5);
`endif

    check_val("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
